piece_window_sampler_seq: RTL and testbench
===========================================

Name: piece_window_sampler_seq

Overview:
- Sequential, parametrised successor to the combinational 6x6 neighbourhood sampler.
- Accepts a request for a WIN x WIN window anchored at (piece_x - ORIGIN_OFS, piece_y - ORIGIN_OFS).
- Scans the board one window column per cycle from a board snapshot taken at request accept, then returns the window on a valid/ready response channel.
- Sits between the game FSM (rotation/move legality checks) and game_state_pkg::game_state_t.

Parameters:
- BOARD_WIDTH, 10, board columns (x).
- BOARD_HEIGHT, 20, board rows (y).
- WIN, 6, window edge length; legal range 2..8.
- ORIGIN_OFS, 1, offset of window top-left from the piece anchor; legal range 0..WIN-1.
- OOB_FILL, 1'b1, value returned for off-board cells.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- state  input  game_state_pkg::game_state_t  live board; only .screen[x][y] is used.
- req_valid  input  1  request strobe.
- req_ready  output  1  high when IDLE.
- piece_x  input  $clog2(BOARD_WIDTH)  anchor x; 0 is left.
- piece_y  input  $clog2(BOARD_HEIGHT)  anchor y; 0 is top.
- piece_mask  input  [WIN-1:0] [WIN-1:0]  piece occupancy, indexed [lx][ly]; used only with COLLISION_DETECT_EN.
- flush  input  1  synchronous abort.
- rsp_valid  output  1  window result valid.
- rsp_ready  input  1  consumer accepts the result.
- window  output  [WIN-1:0] [WIN-1:0]  sampled window, indexed [lx][ly].
- collide  output  1  (window & piece_mask) != 0.

Behaviour:
- Reset values (async, reset_n low):
  - state = IDLE; req_ready = 1; rsp_valid = 0; window = all 0; collide = 0.
  - Internal column counter = 0; snapshot is don't-care.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready: latch piece_x, piece_y, piece_mask and a full copy of state.screen; clear the window register; col = 0; go to SCAN.
- SCAN (exactly WIN cycles, col = 0..WIN-1):
  - req_ready = 0.
  - Each cycle writes window[col][ly] for all ly.
  - World coordinates are computed in signed arithmetic at least $clog2(max(BOARD_WIDTH, BOARD_HEIGHT)) + 2 bits wide:
    - wx = piece_x + col - ORIGIN_OFS
    - wy = piece_y + ly - ORIGIN_OFS
  - Cell value: if wx < 0, wy < 0, wx >= BOARD_WIDTH or wy >= BOARD_HEIGHT, the cell is OOB_FILL; otherwise it is snapshot[wx][wy].
  - The board is never read out of range.
  - After col = WIN-1, go to DONE.
- DONE:
  - rsp_valid = 1; window and collide are stable and held.
  - On rsp_valid && rsp_ready, go to IDLE (req_ready = 1 the following cycle).
- Latency:
  - Accept at cycle N gives rsp_valid at cycle N+WIN+1.
  - Throughput is one request per WIN+2 cycles with rsp_ready tied high.
  - No back-to-back accept in the same cycle as a response handshake.
- The snapshot isolates the result from state.screen changes during SCAN/DONE. The live board is sampled only on the accept cycle.
- Inputs piece_x, piece_y and piece_mask are don't-care outside the accept cycle.
- flush:
  - In any state it forces IDLE on the next edge and drops rsp_valid.
  - window and collide retain their last values.
  - flush has priority over a same-cycle request accept (the request is not accepted) and over a same-cycle rsp handshake.
- Asserting reset_n low mid-SCAN aborts immediately to the reset values.
- piece_x/piece_y beyond board range (e.g. 15 on a 10-wide board) is legal; all affected cells read OOB_FILL.

Optional Feature:
- Macro: COLLISION_DETECT_EN.
- Defined:
  - collide accumulates during SCAN as the OR over cols of |(column & piece_mask[col]); it is cleared on accept.
  - collide is valid with rsp_valid and includes off-board cells (OOB_FILL = 1 gives wall/floor collisions).
- Undefined:
  - collide is tied to 0.
  - piece_mask is unused and is not latched, with no registers inferred.

Test Plan:
- Empty board, piece (4,8), WIN=6, OFS=1 -> rsp_valid exactly 7 cycles after accept; window all 0; collide = 0.
- Empty board, piece (0,0) -> window[0][*] = 1 and window[*][0] = 1, all other cells 0. With a mask bit at [0][2] and COLLISION_DETECT_EN defined, collide = 1.
- screen[9][19] = 1, piece (9,19) -> window[1][1] = 1; lx >= 2 or ly >= 2 read 1 (OOB); window[0][0] = 0.
- Accept with screen[5][5] = 1, then clear screen[5][5] on the next cycle, piece (5,5) -> window[1][1] still 1 (snapshot).
- rsp_ready held low 10 cycles in DONE -> rsp_valid and window stable and req_ready = 0 throughout; raising rsp_ready gives req_ready = 1 on the next cycle.
- flush asserted at SCAN col = 2 together with req_valid -> IDLE next cycle, rsp_valid never asserts, the new request is not taken, and the next request completes normally. Repeat the abort with reset_n low mid-SCAN -> all outputs at reset values.

Source files
------------

// File: rtl/piece_window_sampler_seq_if.sv
// Request/response bundle for the sequential window sampler.
// The requester drives the piece and mask; the sampler returns the window.
interface piece_window_sampler_seq_if #(
    parameter int BOARD_WIDTH  = 10,
    parameter int BOARD_HEIGHT = 20,
    parameter int WIN          = 6
);
    logic                            req_valid;
    logic                            req_ready;
    logic [$clog2(BOARD_WIDTH)-1:0]  piece_x;
    logic [$clog2(BOARD_HEIGHT)-1:0] piece_y;
    logic [WIN-1:0][WIN-1:0]         piece_mask;
    logic                            rsp_valid;
    logic                            rsp_ready;
    logic [WIN-1:0][WIN-1:0]         window;
    logic                            collide;

    modport master (
        output req_valid, piece_x, piece_y, piece_mask, rsp_ready,
        input  req_ready, rsp_valid, window, collide
    );

    modport slave (
        input  req_valid, piece_x, piece_y, piece_mask, rsp_ready,
        output req_ready, rsp_valid, window, collide
    );
endinterface

// File: rtl/piece_window_sampler_seq.sv
// Board snapshot + column-per-cycle WIN x WIN window sampler.
// Define COLLISION_DETECT_EN to accumulate window & piece_mask into collide.
package game_state_pkg;
    localparam int SCREEN_W = 10;
    localparam int SCREEN_H = 20;

    typedef struct packed {
        logic [SCREEN_W-1:0][SCREEN_H-1:0] screen;
    } game_state_t;
endpackage

module piece_window_sampler_seq
    import game_state_pkg::*;
#(
    parameter int   BOARD_WIDTH  = 10,
    parameter int   BOARD_HEIGHT = 20,
    parameter int   WIN          = 6,
    parameter int   ORIGIN_OFS   = 1,
    parameter logic OOB_FILL     = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  game_state_t                state,
    input  logic                       flush,
    piece_window_sampler_seq_if.slave  io
);
    localparam int XW   = $clog2(BOARD_WIDTH);
    localparam int YW   = $clog2(BOARD_HEIGHT);
    localparam int CW   = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int MAXD = (BOARD_WIDTH > BOARD_HEIGHT) ? BOARD_WIDTH
                                                       : BOARD_HEIGHT;
    localparam int CRD  = $clog2(MAXD) + 2;

    localparam logic signed [CRD-1:0] OFS  = CRD'(ORIGIN_OFS);
    localparam logic signed [CRD-1:0] BW   = CRD'(BOARD_WIDTH);
    localparam logic signed [CRD-1:0] BH   = CRD'(BOARD_HEIGHT);
    localparam logic signed [CRD-1:0] ZERO = '0;
    localparam logic [CW-1:0]         LAST = CW'(WIN - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } fsm_t;

    fsm_t cur;
    fsm_t nxt;

    logic [CW-1:0]                          col;
    logic [XW-1:0]                          px;
    logic [YW-1:0]                          py;
    logic [BOARD_WIDTH-1:0][BOARD_HEIGHT-1:0] snap;
    logic [WIN-1:0][WIN-1:0]                win_q;
    logic [WIN-1:0]                         col_bits;
    logic signed [CRD-1:0]                  wx;
    logic signed [CRD-1:0]                  wy;
    logic                                   accept;

    assign accept = (cur == IDLE) && io.req_valid && !flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur <= IDLE;
        end else begin
            cur <= nxt;
        end
    end

    always_comb begin
        nxt = cur;
        if (flush) begin
            nxt = IDLE;
        end else begin
            unique case (cur)
                IDLE: if (io.req_valid)     nxt = SCAN;
                SCAN: if (col == LAST)      nxt = DONE;
                DONE: if (io.rsp_ready)     nxt = IDLE;
                default:                    nxt = IDLE;
            endcase
        end
    end

    // Range test happens before the index so the board is never over-read
    always_comb begin
        col_bits = '0;
        wx = $signed(CRD'(px)) + $signed(CRD'(col)) - OFS;
        wy = '0;
        for (int ly = 0; ly < WIN; ly++) begin
            wy = $signed(CRD'(py)) + $signed(CRD'(ly)) - OFS;
            if (wx < ZERO || wy < ZERO || wx >= BW || wy >= BH) begin
                col_bits[ly] = OOB_FILL;
            end else begin
                col_bits[ly] = snap[wx[XW-1:0]][wy[YW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            snap <= state.screen;
            px   <= io.piece_x;
            py   <= io.piece_y;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col   <= '0;
            win_q <= '0;
        end else if (accept) begin
            col   <= '0;
            win_q <= '0;
        end else if (cur == SCAN && !flush) begin
            win_q[col] <= col_bits;
            col        <= col + 1'b1;
        end
    end

`ifdef COLLISION_DETECT_EN
    logic [WIN-1:0][WIN-1:0] mask_q;
    logic                    coll_q;

    always_ff @(posedge clk) begin
        if (accept) begin
            mask_q <= io.piece_mask;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            coll_q <= 1'b0;
        end else if (accept) begin
            coll_q <= 1'b0;
        end else if (cur == SCAN && !flush) begin
            coll_q <= coll_q | (|(col_bits & mask_q[col]));
        end
    end

    assign io.collide = coll_q;
`else
    logic unused_mask;

    assign unused_mask = ^io.piece_mask;
    assign io.collide  = 1'b0;
`endif

    assign io.req_ready = (cur == IDLE);
    assign io.rsp_valid = (cur == DONE);
    assign io.window    = win_q;
endmodule

// File: tb/tb_piece_window_sampler_seq.sv
// Directed bench for piece_window_sampler_seq (10x20 board, WIN=6, OFS=1).
// Expected windows are flat bit vectors, bit index lx*6+ly.
module tb_piece_window_sampler_seq;
    import game_state_pkg::*;

    localparam int WIN = 6;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    game_state_t st;
    int          n_checks = 0;
    int          n_fail = 0;
    int          lat;
    int          seen;
    logic        exp_coll;

    piece_window_sampler_seq_if #(
        .BOARD_WIDTH (10),
        .BOARD_HEIGHT(20),
        .WIN         (WIN)
    ) io ();

    piece_window_sampler_seq #(
        .BOARD_WIDTH (10),
        .BOARD_HEIGHT(20),
        .WIN         (WIN),
        .ORIGIN_OFS  (1),
        .OOB_FILL    (1'b1)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .state  (st),
        .flush  (flush),
        .io     (io)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic request(input int x, input int y,
                           input logic [35:0] mask, output int n);
        io.piece_x    = 4'(x);
        io.piece_y    = 5'(y);
        io.piece_mask = mask;
        io.req_valid  = 1'b1;
        n = 0;
        tick();
        n++;
        io.req_valid = 1'b0;
        while (!io.rsp_valid && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic release_rsp;
        io.rsp_ready = 1'b1;
        tick();
        io.rsp_ready = 1'b0;
        check("req_ready_after_rsp", 64'(io.req_ready), 64'd1);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req_ready"}, 64'(io.req_ready), 64'd1);
        check({tag, "_rsp_valid"}, 64'(io.rsp_valid), 64'd0);
        check({tag, "_window"},    64'(io.window),    64'd0);
        check({tag, "_collide"},   64'(io.collide),   64'd0);
    endtask

    initial begin
        st            = '0;
        io.req_valid  = 1'b0;
        io.rsp_ready  = 1'b0;
        io.piece_x    = '0;
        io.piece_y    = '0;
        io.piece_mask = '0;
        #12;
        check_reset("reset");
        reset_n = 1'b1;
        tick();

        // empty board, centre of the well
        request(4, 8, 36'h0, lat);
        check("empty_latency", 64'(lat), 64'd7);
        check("empty_window", 64'(io.window), 64'd0);
        check("empty_collide", 64'(io.collide), 64'd0);
        release_rsp();

        // top-left corner: column 0 and row 0 fall off the board
`ifdef COLLISION_DETECT_EN
        exp_coll = 1'b1;
`else
        exp_coll = 1'b0;
`endif
        request(0, 0, 36'h4, lat);
        check("corner_latency", 64'(lat), 64'd7);
        check("corner_window", 64'(io.window), 64'h4104107F);
        check("corner_collide", 64'(io.collide), 64'(exp_coll));
        release_rsp();

        // bottom-right corner with one occupied cell
        st.screen[9][19] = 1'b1;
        request(9, 19, 36'h0, lat);
        check("br_latency", 64'(lat), 64'd7);
        check("br_window", 64'(io.window), 64'hFFFFFFFBC);
        check("br_collide", 64'(io.collide), 64'd0);
        release_rsp();
        st = '0;

        // snapshot isolates the live board change after accept
        st.screen[5][5] = 1'b1;
        io.piece_x      = 4'd5;
        io.piece_y      = 5'd5;
        io.piece_mask   = '0;
        io.req_valid    = 1'b1;
        tick();
        io.req_valid    = 1'b0;
        st.screen[5][5] = 1'b0;
        lat = 1;
        while (!io.rsp_valid && lat < 50) begin
            tick();
            lat++;
        end
        check("snap_latency", 64'(lat), 64'd7);
        check("snap_window", 64'(io.window), 64'h80);

        // consumer stalls in DONE
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_rsp_valid", 64'(io.rsp_valid), 64'd1);
            check("stall_window", 64'(io.window), 64'h80);
            check("stall_req_ready", 64'(io.req_ready), 64'd0);
        end
        release_rsp();

        // flush in IDLE wins over a same-cycle request
        io.piece_x   = 4'd4;
        io.piece_y   = 5'd8;
        io.req_valid = 1'b1;
        flush        = 1'b1;
        tick();
        io.req_valid = 1'b0;
        flush        = 1'b0;
        check("idle_flush_req_ready", 64'(io.req_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < WIN + 2; i++) begin
            tick();
            if (io.rsp_valid || !io.req_ready) seen++;
        end
        check("idle_flush_no_accept", 64'(seen), 64'd0);

        // flush at col 2 together with a new request
        io.req_valid = 1'b1;
        tick();
        io.req_valid = 1'b0;
        tick();
        tick();
        check("scan_req_ready", 64'(io.req_ready), 64'd0);
        flush        = 1'b1;
        io.req_valid = 1'b1;
        tick();
        flush        = 1'b0;
        io.req_valid = 1'b0;
        check("scan_flush_req_ready", 64'(io.req_ready), 64'd1);
        check("scan_flush_rsp_valid", 64'(io.rsp_valid), 64'd0);
        seen = 0;
        for (int i = 0; i < WIN + 2; i++) begin
            tick();
            if (io.rsp_valid || !io.req_ready) seen++;
        end
        check("scan_flush_no_accept", 64'(seen), 64'd0);

        // next request completes normally
        st.screen[4][8] = 1'b1;
        request(4, 8, 36'h0, lat);
        check("post_flush_latency", 64'(lat), 64'd7);
        check("post_flush_window", 64'(io.window), 64'h80);
        release_rsp();
        st = '0;

        // reset mid-SCAN after columns have been written
        io.req_valid = 1'b1;
        io.piece_x   = 4'd0;
        io.piece_y   = 5'd0;
        tick();
        io.req_valid = 1'b0;
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check_reset("mid_scan_reset");
        #3;
        reset_n = 1'b1;
        tick();
        check("after_reset_req_ready", 64'(io.req_ready), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
